vec_reg_ctrl: RTL and testbench

VEC_REG_CTRL -- requirements
Module: vec_reg_ctrl

---
 rtl/vec_reg_ctrl.sv | 164 ++++++++++++++++
 tb/tb_vec_reg_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_reg_ctrl.sv
// Single-issue controller that steers register-bank read/write ports around an external execution unit.
// Optional EXEC watchdog is built when VEC_REG_CTRL_TIMEOUT_EN is defined; otherwise err_timeout is tied low.
module vec_reg_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [1:0] instr_op,
    input  logic [3:0] instr_rd,
    input  logic [3:0] instr_rs1,
    input  logic [3:0] instr_rs2,
    output logic [3:0] out_sel_a,
    output logic [3:0] out_sel_b,
    output logic       out_en_a,
    output logic       out_en_b,
    output logic [3:0] in_sel,
    output logic       write,
    output logic       exec_start,
    input  logic       exec_done,
    output logic       busy,
    output logic       err_timeout
);

    localparam logic [1:0] OP_BIN  = 2'b00;
    localparam logic [1:0] OP_READ = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("vec_reg_ctrl: TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        EXEC  = 2'd2,
        WB    = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] op_q, op_d;
    logic [3:0] rd_q, rd_d;
    logic [3:0] rs1_q, rs1_d;
    logic [3:0] rs2_q, rs2_d;

    logic       ready_q, busy_q, start_q, write_q;
    logic       en_a_q, en_b_q;
    logic [3:0] sel_a_q, sel_b_q;

    logic       active_d, use_a_d, use_b_d;

`ifdef VEC_REG_CTRL_TIMEOUT_EN
    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
`ifdef VEC_REG_CTRL_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (instr_valid && ready_q) begin
                    op_d    = instr_op;
                    rd_d    = instr_rd;
                    rs1_d   = instr_rs1;
                    rs2_d   = instr_rs2;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = EXEC;
`ifdef VEC_REG_CTRL_TIMEOUT_EN
                cnt_d   = 8'd0;
`endif
            end
            EXEC: begin
                // Completion wins over the watchdog when both land on the same cycle.
                if (exec_done) begin
                    state_d = (op_q == OP_READ) ? IDLE : WB;
                end
`ifdef VEC_REG_CTRL_TIMEOUT_EN
                else if (cnt_q == LAST_COUNT) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign active_d = (state_d != IDLE);
    assign use_a_d  = active_d && (op_d != OP_LOAD);
    assign use_b_d  = active_d && (op_d == OP_BIN);

    // Outputs are registered from the next-state view so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_BIN;
            rd_q    <= 4'd0;
            rs1_q   <= 4'd0;
            rs2_q   <= 4'd0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            write_q <= 1'b0;
            en_a_q  <= 1'b0;
            en_b_q  <= 1'b0;
            sel_a_q <= 4'd0;
            sel_b_q <= 4'd0;
`ifdef VEC_REG_CTRL_TIMEOUT_EN
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            ready_q <= (state_d == IDLE);
            busy_q  <= active_d;
            start_q <= (state_d == ISSUE);
            write_q <= (state_d == WB);
            en_a_q  <= use_a_d;
            en_b_q  <= use_b_d;
            sel_a_q <= use_a_d ? rs1_d : 4'd0;
            sel_b_q <= use_b_d ? rs2_d : 4'd0;
`ifdef VEC_REG_CTRL_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign instr_ready = ready_q;
    assign busy        = busy_q;
    assign exec_start  = start_q;
    assign write       = write_q;
    assign in_sel      = rd_q;
    assign out_en_a    = en_a_q;
    assign out_en_b    = en_b_q;
    assign out_sel_a   = sel_a_q;
    assign out_sel_b   = sel_b_q;
`ifdef VEC_REG_CTRL_TIMEOUT_EN
    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_vec_reg_ctrl.sv
// Bench for vec_reg_ctrl: an instruction-lifetime model checked every cycle, plus hand-computed
// expectations for the directed scenarios. Watchdog scenario runs when VEC_REG_CTRL_TIMEOUT_EN is defined.
module tb_vec_reg_ctrl;

`ifdef VEC_REG_CTRL_TIMEOUT_EN
    localparam int TbTimeout = 4;
`else
    localparam int TbTimeout = 255;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_valid;
    logic       instr_ready;
    logic [1:0] instr_op;
    logic [3:0] instr_rd, instr_rs1, instr_rs2;
    logic [3:0] out_sel_a, out_sel_b;
    logic       out_en_a, out_en_b;
    logic [3:0] in_sel;
    logic       write, exec_start, exec_done, busy, err_timeout;

    vec_reg_ctrl #(.TIMEOUT_CYCLES(TbTimeout)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
        .out_sel_a(out_sel_a), .out_sel_b(out_sel_b), .out_en_a(out_en_a), .out_en_b(out_en_b),
        .in_sel(in_sel), .write(write), .exec_start(exec_start), .exec_done(exec_done),
        .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Model: one instruction at a time, tracked by its age and whether completion was seen.
    bit       modelValid = 0;
    bit       mBusy, mReady, mDoneSeen, mErr;
    int       mAge, mIdleExec;
    bit [1:0] mOp;
    bit [3:0] mRs1, mRs2, mLastRd;

    function automatic bit writesBack(input bit [1:0] op);
        return op != 2'b10;
    endfunction

    function void modelStep();
        if (!rst_n) begin
            mBusy = 0; mReady = 0; mDoneSeen = 0; mErr = 0;
            mAge = 0; mIdleExec = 0; mLastRd = 0;
            modelValid = 1;
            return;
        end
        if (mBusy) begin
            if (mAge == 1) begin
                mAge = 2;
            end else if (mDoneSeen) begin
                mBusy = 0;
            end else if (exec_done) begin
                if (writesBack(mOp)) begin
                    mDoneSeen = 1;
                    mAge++;
                end else begin
                    mBusy = 0;
                end
            end else begin
                mIdleExec++;
                mAge++;
`ifdef VEC_REG_CTRL_TIMEOUT_EN
                if (mIdleExec == TbTimeout) begin
                    mBusy = 0;
                    mErr  = 1;
                end
`endif
            end
        end else if (instr_valid && mReady) begin
            mBusy = 1; mAge = 1; mDoneSeen = 0; mIdleExec = 0;
            mOp = instr_op; mRs1 = instr_rs1; mRs2 = instr_rs2; mLastRd = instr_rd;
        end
        mReady = !mBusy;
    endfunction

    int cycleNum = 0;
    int hsCycles[$];
    int busyCount = 0;
    int writeCount = 0;
    logic [3:0] writeSel = 0;

    always @(posedge clk) begin
        bit expEnA, expEnB;
        if (rst_n && instr_valid && instr_ready) hsCycles.push_back(cycleNum);
        modelStep();
        cycleNum++;
        #1;
        if (modelValid) begin
            expEnA = mBusy && (mOp != 2'b11);
            expEnB = mBusy && (mOp == 2'b00);
            checkOutput("instr_ready", instr_ready, mReady);
            checkOutput("busy", busy, mBusy);
            checkOutput("exec_start", exec_start, mBusy && mAge == 1);
            checkOutput("write", write, mBusy && mDoneSeen);
            checkOutput("in_sel", in_sel, mLastRd);
            checkOutput("out_en_a", out_en_a, expEnA);
            checkOutput("out_en_b", out_en_b, expEnB);
            checkOutput("out_sel_a", out_sel_a, expEnA ? mRs1 : 4'd0);
            checkOutput("out_sel_b", out_sel_b, expEnB ? mRs2 : 4'd0);
            checkOutput("err_timeout", err_timeout, mErr);
            if (busy === 1'b1) busyCount++;
            if (write === 1'b1) begin
                writeCount++;
                writeSel = in_sel;
            end
        end
    end

    // Presents one instruction and returns at the negedge of the ISSUE cycle.
    task automatic applyStimulus(input logic [1:0] op, input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2);
        int waited = 0;
        @(negedge clk);
        instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
        instr_valid = 1'b1;
        while (instr_ready !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (instr_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL handshake actual=no_ready expected=ready within 40 cycles");
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
        instr_valid = 1'b0;
    endtask

    // Called from the ISSUE-cycle negedge (cycle 1); raises exec_done for cycle k.
    task automatic pulseDone(input int k);
        repeat (k - 1) @(negedge clk);
        exec_done = 1'b1;
        @(negedge clk);
        exec_done = 1'b0;
    endtask

    task automatic clearCounts();
        busyCount = 0;
        writeCount = 0;
        writeSel = 4'hx;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout actual=running expected=finished");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        rst_n = 1'b0; instr_valid = 1'b0; exec_done = 1'b0;
        instr_op = 2'b00; instr_rd = 0; instr_rs1 = 0; instr_rs2 = 0;

        // Reset values, then ready rises once reset is released.
        repeat (2) @(negedge clk);
        checkOutput("rst_ready", instr_ready, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_write", write, 0);
        checkOutput("rst_in_sel", in_sel, 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_ready", instr_ready, 1);

        // Binary op with done in cycle 5: busy cycles 1..6, one write to r3.
        clearCounts();
        applyStimulus(2'b00, 4'd3, 4'd1, 4'd2);
        checkOutput("bin_start", exec_start, 1);
        checkOutput("bin_sel_a", out_sel_a, 1);
        checkOutput("bin_sel_b", out_sel_b, 2);
        checkOutput("bin_en_b", out_en_b, 1);
        pulseDone(5);
        repeat (2) @(negedge clk);
        checkOutput("bin_busy_cycles", busyCount, 6);
        checkOutput("bin_writes", writeCount, 1);
        checkOutput("bin_write_sel", writeSel, 3);

        // Readout: port A only, no write, idle the cycle after done.
        clearCounts();
        applyStimulus(2'b10, 4'd5, 4'd15, 4'd9);
        checkOutput("rd_en_a", out_en_a, 1);
        checkOutput("rd_sel_a", out_sel_a, 15);
        checkOutput("rd_en_b", out_en_b, 0);
        checkOutput("rd_sel_b", out_sel_b, 0);
        pulseDone(2);
        checkOutput("rd_idle_busy", busy, 0);
        checkOutput("rd_idle_ready", instr_ready, 1);
        checkOutput("rd_writes", writeCount, 0);

        // Load to r0 with immediate done; next instruction (rd==rs1) held waiting is accepted 4 cycles later.
        clearCounts();
        applyStimulus(2'b11, 4'd0, 4'd4, 4'd6);
        checkOutput("ld_en_a", out_en_a, 0);
        fork
            pulseDone(2);
            applyStimulus(2'b01, 4'd9, 4'd9, 4'd0);
        join
        checkOutput("ld_writes", writeCount, 1);
        checkOutput("ld_write_sel", writeSel, 0);
        checkOutput("issue_interval", hsCycles[hsCycles.size()-1] - hsCycles[hsCycles.size()-2], 4);
        pulseDone(2);
        @(negedge clk);
        checkOutput("un_writes", writeCount, 2);
        checkOutput("un_write_sel", writeSel, 9);

        // Reset during WB of a unary op aborts the write; the next instruction runs normally.
        applyStimulus(2'b01, 4'd7, 4'd2, 4'd0);
        pulseDone(2);
        checkOutput("wb_write_before_rst", write, 1);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abort_write", write, 0);
        checkOutput("abort_in_sel", in_sel, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_ready", instr_ready, 0);
        rst_n = 1'b1;
        clearCounts();
        applyStimulus(2'b00, 4'd11, 4'd4, 4'd5);
        pulseDone(2);
        repeat (2) @(negedge clk);
        checkOutput("after_rst_writes", writeCount, 1);
        checkOutput("after_rst_sel", writeSel, 11);

        // exec_done already high in IDLE: ISSUE still happens, then a single write.
        clearCounts();
        exec_done = 1'b1;
        applyStimulus(2'b00, 4'd12, 4'd13, 4'd14);
        @(negedge clk);
        @(negedge clk);
        exec_done = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("early_done_busy", busyCount, 3);
        checkOutput("early_done_writes", writeCount, 1);
        checkOutput("early_done_sel", writeSel, 12);

`ifdef VEC_REG_CTRL_TIMEOUT_EN
        // Watchdog: no done ever, 4 EXEC cycles then idle with the sticky error.
        clearCounts();
        applyStimulus(2'b00, 4'd5, 4'd1, 4'd2);
        repeat (8) @(negedge clk);
        checkOutput("wd_busy_cycles", busyCount, 5);
        checkOutput("wd_writes", writeCount, 0);
        checkOutput("wd_err", err_timeout, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("wd_err_cleared", err_timeout, 0);
        @(negedge clk);
`else
        // No watchdog: a long EXEC simply waits for done.
        clearCounts();
        applyStimulus(2'b01, 4'd10, 4'd8, 4'd0);
        pulseDone(21);
        repeat (2) @(negedge clk);
        checkOutput("long_busy_cycles", busyCount, 22);
        checkOutput("long_writes", writeCount, 1);
        checkOutput("long_err", err_timeout, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
